// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial sequence detector.
// Holds PAT_W limits, the default counter width and the overlap mode encodings.
package seq_det_pkg;
  localparam int PAT_W_MIN     = 2;
  localparam int PAT_W_MAX     = 16;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;
endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with a synchronous clear that outranks increment.
// Only instantiated by seq_det_param when SEQ_DET_COUNT_EN is defined.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern and overlap/non-overlap modes.
// Define SEQ_DET_COUNT_EN to add the saturating match counter (cnt_clr_i, match_cnt_o).
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011,
  parameter int               CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_i,
  input  logic             valid_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             pat_load_i,
  input  logic             overlap_i,
`ifdef SEQ_DET_COUNT_EN
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] match_cnt_o,
`endif
  output logic             pattern_o
);
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  generate
    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_det_param: PAT_W outside legal range");
    end
  endgenerate

  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic [FILL_W-1:0] r_fill;
  logic              r_pattern;

  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_match;

  assign w_hist_next = {r_hist[PAT_W-2:0], d_i};
  assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
  // A load cycle never matches: its data bit is discarded.
  assign w_match     = valid_i && !pat_load_i &&
                       (w_fill_next == FILL_FULL) && (w_hist_next == r_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= PAT_DEFAULT;
      r_pattern <= 1'b0;
    end else begin
      r_pattern <= w_match;
      if (pat_load_i) begin
        r_pat  <= pat_i;
        r_fill <= '0;
      end else if (valid_i) begin
        r_hist <= w_hist_next;
        // overlap_i only matters on the matching edge.
        if (w_match && (ovl_mode_e'(overlap_i) == OVL_OFF)) begin
          r_fill <= '0;
        end else begin
          r_fill <= w_fill_next;
        end
      end
    end
  end

  assign pattern_o = r_pattern;

`ifdef SEQ_DET_COUNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr_i),
    .inc(w_match),
    .cnt(match_cnt_o)
  );
`endif
endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_DEFAULT, default 4'b1011: pattern loaded at reset, PAT_W bits wide.
REQ-003 Parameter CNT_W, default 16: width of the match counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 d_i  input  1  serial data bit, sampled only when valid_i=1.
REQ-007 valid_i  input  1  qualifies d_i for the current cycle.
REQ-008 pat_i  input  PAT_W  new pattern value; first-received bit maps to the MSB.
REQ-009 pat_load_i  input  1  loads pat_i into the pattern register.
REQ-010 overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 cnt_clr_i  input  1  clears match_cnt_o (present only with SEQ_DET_COUNT_EN).
REQ-012 pattern_o  output  1  registered, one-cycle match pulse.
REQ-013 match_cnt_o  output  CNT_W  saturating match count (present only with SEQ_DET_COUNT_EN).

Function
REQ-014 Shift rule: on a valid_i=1 cycle, the block SHALL shift d_i into a PAT_W-bit history register (newest bit at LSB) and increment a fill counter that saturates at PAT_W.
REQ-015 Hold rule: on a valid_i=0 cycle, the block SHALL hold history and fill unchanged.
REQ-016 Match condition: a match SHALL occur on a valid cycle when post-shift fill equals PAT_W and post-shift history equals the pattern register.
REQ-017 pattern_o SHALL be 1 for exactly the one cycle after the matching edge and 0 otherwise (Moore, registered, latency 1 cycle).
REQ-018 Overlap mode (overlap_i=1): after a match, history and fill SHALL be retained, so a suffix of the matched bits can start the next match.
REQ-019 Non-overlap mode (overlap_i=0): after a match, fill SHALL be cleared to 0, so PAT_W fresh valid bits are needed before the next match.
REQ-020 overlap_i SHALL be sampled on the matching edge only; changing it mid-stream SHALL not alter history.
REQ-021 Pattern load: pat_load_i=1 SHALL load pat_i and clear fill to 0; the d_i of that cycle SHALL be discarded and no match is evaluated in that cycle.
REQ-022 Load priority: pat_load_i SHALL take priority over valid_i when both are high in the same cycle.
REQ-023 Gaps: valid_i gaps of any length SHALL not break a partially received pattern.
REQ-024 Counter (with macro): match_cnt_o SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-025 Counter clear priority (with macro): cnt_clr_i SHALL clear match_cnt_o to 0; if cnt_clr_i and a match occur in the same cycle, the clear SHALL take priority and the result is 0.

Reset
REQ-026 rst=1 at a rising edge SHALL clear history and fill, set pattern_o=0 and match_cnt_o=0, and load PAT_DEFAULT into the pattern register.
REQ-027 Reset SHALL override all other inputs, and a reset mid-pattern SHALL discard all partial progress.
REQ-028 After reset is released, the first match SHALL require PAT_W valid bits.

Configuration
REQ-029 Macro SEQ_DET_COUNT_EN, when defined, SHALL compile in the counter logic, cnt_clr_i and match_cnt_o.
REQ-030 When SEQ_DET_COUNT_EN is undefined, those ports and the counter logic SHALL be absent, and detection behaviour SHALL be identical to the defined case.

Structure
REQ-031 Shared package seq_det_pkg SHALL hold the PAT_W range limits (2, 16), the default CNT_W, and the overlap mode encodings (OVL_ON=1, OVL_OFF=0).
REQ-032 The saturating counter SHALL be a sub-module named seq_det_sat_cnt (parameter CNT_W; inputs clk, rst, clr, inc; output cnt), instantiated only under SEQ_DET_COUNT_EN.

Verification
REQ-033 Overlap count: PAT_W=4, pattern 1011, overlap_i=1, valid stream 1011011 -> pattern_o pulses twice, the cycle after bit 4 and the cycle after bit 7; match_cnt_o=2.
REQ-034 Non-overlap count: same stream with overlap_i=0 -> exactly one pulse, after bit 4; match_cnt_o=1.
REQ-035 Gap and mid-stream reset: stream 1,0,gap of 3 cycles,1,1 -> one pulse after the final 1; separately, rst asserted after 101 then 1 applied -> no pulse.
REQ-036 Pattern load: pat_load_i with pat_i=0110 while d_i=1, valid_i=1 -> that bit is ignored; then 0110 -> one pulse, and stream 1011 before the load -> none.
REQ-037 Saturation and clear: CNT_W=2, 5 matches -> match_cnt_o=3; cnt_clr_i coincident with the 6th match -> 0.
REQ-038 Random stream: seed 123456, 540 random valid bits, pattern 1011, both modes -> pulse count equals the bench reference-model count; without SEQ_DET_COUNT_EN the pulse count is identical.
